iob_timer_alarm: RTL and testbench
==================================

IOB_TIMER_ALARM -- requirements
Module: iob_timer_alarm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning timer word width; the time and compare values are 2*DATA_W bits.
REQ-002 SHALL have parameter MISSED_W, default 8, meaning missed-event counter width.
REQ-003 SHALL have port clk_i  input  1  meaning the single clock; all state is sampled on its rising edge.
REQ-004 SHALL have port cke_i  input  1  meaning clock enable; when low, all state holds.
REQ-005 SHALL have port arst_i  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port time_i  input  2*DATA_W  meaning the current free-running time value.
REQ-007 SHALL have port cmp_lo_i  input  DATA_W  meaning the target time, low word.
REQ-008 SHALL have port cmp_hi_i  input  DATA_W  meaning the target time, high word.
REQ-009 SHALL have port cmp_wen_i  input  1  meaning load both target words atomically.
REQ-010 SHALL have port arm_i  input  1  meaning arm the alarm.
REQ-011 SHALL have port disarm_i  input  1  meaning disarm the alarm.
REQ-012 SHALL have port ack_i  input  1  meaning clear the pending interrupt.
REQ-013 SHALL have port irq_o  output  1  meaning interrupt, held high until acknowledged.
REQ-014 SHALL have port armed_o  output  1  meaning the alarm is armed or pending.
REQ-015 SHALL have port missed_o  output  MISSED_W  meaning the saturating count of fires that occurred while irq_o was already high.

Function
REQ-016 SHALL use three states: IDLE, ARMED, PENDING.
REQ-017 SHALL store the target {cmp_hi_i,cmp_lo_i} into the cmp register on cmp_wen_i, in any state; the new value is used by the compare in the following cycle.
REQ-018 SHALL detect a hit when armed and time_i >= cmp (unsigned 2*DATA_W compare), registered, so irq_o rises exactly 1 cycle after the hit condition.
REQ-019 SHALL go IDLE->ARMED on arm_i, and a target already in the past SHALL fire on the next compare.
REQ-020 SHALL go ARMED->PENDING on a hit (one-shot mode), setting irq_o=1; PENDING->IDLE on ack_i.
REQ-021 SHALL go from any state to IDLE on disarm_i, clearing irq_o; when disarm_i and arm_i occur together, disarm_i SHALL win.
REQ-022 SHALL keep irq_o high when a hit and ack_i occur in the same cycle (the fire wins), and SHALL increment missed_o only if irq_o was already high before that cycle.
REQ-023 SHALL saturate missed_o at 2^MISSED_W-1 and clear it on arm_i.
REQ-024 SHALL drive armed_o=1 in ARMED and PENDING (periodic) and in ARMED (one-shot).
REQ-025 SHALL ignore ack_i when irq_o=0.

Reset
REQ-026 SHALL, on arst_i, set state=IDLE, cmp=0, irq_o=0, armed_o=0, missed_o=0, and period=0, taking effect immediately and independent of clk_i and cke_i.
REQ-027 SHALL abandon any operation in progress when reset is asserted, and leave irq_o low after reset release.

Configuration
REQ-028 SHALL, with IOB_TIMER_ALARM_PERIODIC_EN defined, add the ports period_i (input, 2*DATA_W) and period_wen_i (input, 1); a hit sets irq_o, does cmp <= cmp + period (mod 2^(2*DATA_W)), and stays ARMED.
REQ-029 SHALL, with IOB_TIMER_ALARM_PERIODIC_EN defined, treat a zero period as one-shot behaviour.
REQ-030 SHALL, without IOB_TIMER_ALARM_PERIODIC_EN, omit those ports and the adder and operate one-shot only.

Structure
REQ-031 SHALL place the state encoding localparams (IDLE=0, ARMED=1, PENDING=2) and the MISSED_W default in shared header iob_timer_alarm_pkg.
REQ-032 SHALL factor the 2*DATA_W compare and the reload add into sub-module iob_timer_alarm_cmp.

Verification
REQ-033 SHALL verify: cmp=100, arm at time 50 -> irq_o rises in the cycle after time_i=100; ack -> irq_o=0, state IDLE.
REQ-034 SHALL verify: cmp=10, arm at time 500 -> irq_o=1 two cycles after arm_i.
REQ-035 SHALL verify: cmp=0xFFFFFFFF_FFFFFFF0, period=0x20 (periodic) -> after the fire, cmp=0x10 (wrap) and a second irq occurs at time 0x10 following time wrap.
REQ-036 SHALL verify: periodic mode, period=4, no ack for 3 periods -> missed_o=2 and irq_o stays 1; same-cycle ack and hit -> irq_o stays 1.
REQ-037 SHALL verify: arm_i and disarm_i in the same cycle -> IDLE; cke_i=0 across a hit -> no fire until cke_i=1.
REQ-038 SHALL verify: arst_i asserted while PENDING -> irq_o=0, missed_o=0 asynchronously.

Source files
------------

// File: rtl/iob_timer_alarm_pkg.sv
// Shared state encoding and defaults for the 2*DATA_W-bit timer alarm.
// Imported by iob_timer_alarm; see that file for the IOB_TIMER_ALARM_PERIODIC_EN option.
package iob_timer_alarm_pkg;

    localparam int MISSED_W_DEF = 8;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] PENDING = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_ARMED   = ARMED,
        ST_PENDING = PENDING
    } state_t;

    // PENDING still counts as armed only when the alarm can reload itself
    function automatic logic state_is_armed(input state_t st, input logic periodic);
        return (st == ST_ARMED) || (periodic && (st == ST_PENDING));
    endfunction

endpackage

// File: rtl/iob_timer_alarm_cmp.sv
// Unsigned time-versus-target compare and, with IOB_TIMER_ALARM_PERIODIC_EN,
// the wrapping target + period reload adder.
module iob_timer_alarm_cmp #(
    parameter int W = 64
) (
    input  logic [W-1:0] now,
    input  logic [W-1:0] target,
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    input  logic [W-1:0] period,
    output logic [W-1:0] reload,
`endif
    output logic         reached
);

    assign reached = (now >= target);

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    // Sum is truncated to W bits so the next target wraps with the timer
    assign reload = target + period;
`endif

endmodule

// File: rtl/iob_timer_alarm.sv
// One-shot timer alarm with registered hit detection and a saturating missed counter.
// Define IOB_TIMER_ALARM_PERIODIC_EN to add the period register and periodic reload.
module iob_timer_alarm
    import iob_timer_alarm_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MISSED_W = MISSED_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic [2*DATA_W-1:0]   time_i,
    input  logic [DATA_W-1:0]     cmp_lo_i,
    input  logic [DATA_W-1:0]     cmp_hi_i,
    input  logic                  cmp_wen_i,
    input  logic                  arm_i,
    input  logic                  disarm_i,
    input  logic                  ack_i,
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    input  logic [2*DATA_W-1:0]   period_i,
    input  logic                  period_wen_i,
`endif
    output logic                  irq_o,
    output logic                  armed_o,
    output logic [MISSED_W-1:0]   missed_o
);

    localparam int TW = 2 * DATA_W;
    localparam logic [MISSED_W-1:0] MISSED_MAX = '1;

    state_t              state_q, state_d;
    logic [TW-1:0]       cmp_q, cmp_d;
    logic                irq_q, irq_d;
    logic [MISSED_W-1:0] missed_q, missed_d;
    logic                reached;
    logic                hit;

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    logic [TW-1:0]       period_q, period_d;
    logic [TW-1:0]       reload;

    iob_timer_alarm_cmp #(.W(TW)) u_cmp (
        .now     (time_i),
        .target  (cmp_q),
        .period  (period_q),
        .reload  (reload),
        .reached (reached)
    );
`else
    iob_timer_alarm_cmp #(.W(TW)) u_cmp (
        .now     (time_i),
        .target  (cmp_q),
        .reached (reached)
    );
`endif

    assign hit = (state_q == ST_ARMED) && reached;

    // Priority, lowest to highest: ack, hit, arm, target load, disarm
    always_comb begin
        state_d  = state_q;
        cmp_d    = cmp_q;
        irq_d    = irq_q;
        missed_d = missed_q;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        period_d = period_wen_i ? period_i : period_q;
`endif

        if (ack_i && irq_q) begin
            irq_d = 1'b0;
            if (state_q == ST_PENDING) begin
                state_d = ST_IDLE;
            end
        end

        if (hit) begin
            irq_d = 1'b1;
            if (irq_q && (missed_q != MISSED_MAX)) begin
                missed_d = missed_q + 1'b1;
            end
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
            if (period_q != '0) begin
                cmp_d = reload;
            end else begin
                state_d = ST_PENDING;
            end
`else
            state_d = ST_PENDING;
`endif
        end

        if (arm_i) begin
            missed_d = '0;
            if (state_q == ST_IDLE) begin
                state_d = ST_ARMED;
            end
        end

        if (cmp_wen_i) begin
            cmp_d = {cmp_hi_i, cmp_lo_i};
        end

        if (disarm_i) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= ST_IDLE;
            cmp_q    <= '0;
            irq_q    <= 1'b0;
            missed_q <= '0;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
            period_q <= '0;
`endif
        end else if (cke_i) begin
            state_q  <= state_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
            missed_q <= missed_d;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
            period_q <= period_d;
`endif
        end
    end

    assign irq_o    = irq_q;
    assign missed_o = missed_q;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    assign armed_o  = state_is_armed(state_q, 1'b1);
`else
    assign armed_o  = state_is_armed(state_q, 1'b0);
`endif

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Scoreboard bench for iob_timer_alarm: stimulus pushes expected outputs, a monitor pops and compares.
// Periodic scenarios run only when IOB_TIMER_ALARM_PERIODIC_EN is defined.
module tb_iob_timer_alarm;

    typedef struct {
        string      name;
        logic       irq;
        logic       armed;
        logic [7:0] missed;
    } exp_t;

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    localparam logic PA = 1'b1;
`else
    localparam logic PA = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        cke = 1'b1;
    logic        arst = 1'b1;
    logic [63:0] time_v = '0;
    logic [31:0] cmp_lo = '0;
    logic [31:0] cmp_hi = '0;
    logic        cmp_wen = 1'b0;
    logic        arm = 1'b0;
    logic        disarm = 1'b0;
    logic        ack = 1'b0;
    logic        irq;
    logic        armed;
    logic [7:0]  missed;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
    logic [63:0] period_v = '0;
    logic        period_wen = 1'b0;
`endif

    exp_t exp_q[$];
    event sample_now;
    int   total = 0;
    int   bad = 0;

    iob_timer_alarm dut (
        .clk_i        (clk),
        .cke_i        (cke),
        .arst_i       (arst),
        .time_i       (time_v),
        .cmp_lo_i     (cmp_lo),
        .cmp_hi_i     (cmp_hi),
        .cmp_wen_i    (cmp_wen),
        .arm_i        (arm),
        .disarm_i     (disarm),
        .ack_i        (ack),
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        .period_i     (period_v),
        .period_wen_i (period_wen),
`endif
        .irq_o        (irq),
        .armed_o      (armed),
        .missed_o     (missed)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input exp_t e);
        total++;
        if (irq !== e.irq || armed !== e.armed || missed !== e.missed) begin
            bad++;
            $display("[TB] FAIL %s: got irq=%0b armed=%0b missed=%0d, want irq=%0b armed=%0b missed=%0d",
                     e.name, irq, armed, missed, e.irq, e.armed, e.missed);
        end
    endtask

    // Monitor: outputs settle after each rising edge, or right after an async reset
    initial begin
        forever begin
            @(posedge clk or sample_now);
            #2;
            while (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    // Inputs are set at a falling edge; expectation refers to outputs after the next rising edge
    task automatic applyStimulus(input string name, input bit chk, input logic e_irq,
                                 input logic e_armed, input logic [7:0] e_missed);
        exp_t e;
        if (chk) begin
            e.name = name; e.irq = e_irq; e.armed = e_armed; e.missed = e_missed;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0; disarm = 1'b0; ack = 1'b0; cmp_wen = 1'b0;
`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        period_wen = 1'b0;
`endif
    endtask

    task automatic setCmp(input logic [63:0] v);
        cmp_hi = v[63:32];
        cmp_lo = v[31:0];
        cmp_wen = 1'b1;
    endtask

    task automatic asyncResetCheck(input string name);
        exp_t e;
        #1 arst = 1'b1;
        e.name = name; e.irq = 1'b0; e.armed = 1'b0; e.missed = 8'd0;
        exp_q.push_back(e);
        -> sample_now;
        #3;
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        arst = 1'b0;
        applyStimulus("reset_state", 1, 0, 0, 8'd0);

        // Future target reached by a counting timer
        time_v = 64'd40; setCmp(64'd100);
        applyStimulus("cmp_load_idle", 1, 0, 0, 8'd0);
        time_v = 64'd50; arm = 1'b1;
        applyStimulus("arm_a", 1, 0, 1, 8'd0);
        for (int t = 51; t <= 99; t++) begin
            time_v = 64'(t);
            applyStimulus("no_early_fire", t == 99, 0, 1, 8'd0);
        end
        time_v = 64'd100;
        applyStimulus("fire_at_100", 1, 1, PA, 8'd0);
        time_v = 64'd101; ack = 1'b1;
        applyStimulus("ack_clears", 1, 0, 0, 8'd0);
        time_v = 64'd102;
        applyStimulus("stays_idle", 1, 0, 0, 8'd0);
        time_v = 64'd103; ack = 1'b1;
        applyStimulus("ack_idle", 1, 0, 0, 8'd0);

        // Target already in the past
        time_v = 64'd490; setCmp(64'd10);
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'd500; arm = 1'b1;
        applyStimulus("arm_b", 1, 0, 1, 8'd0);
        time_v = 64'd501;
        applyStimulus("fire_past", 1, 1, PA, 8'd0);
        time_v = 64'd502; disarm = 1'b1;
        applyStimulus("disarm_pending", 1, 0, 0, 8'd0);
        time_v = 64'd503; arm = 1'b1; disarm = 1'b1;
        applyStimulus("arm_disarm_same", 1, 0, 0, 8'd0);
        time_v = 64'd504;
        applyStimulus("still_idle", 1, 0, 0, 8'd0);

        // Clock enable low across the hit
        time_v = 64'd590; setCmp(64'd600);
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'd595; arm = 1'b1;
        applyStimulus("arm_d", 1, 0, 1, 8'd0);
        cke = 1'b0;
        for (int t = 596; t <= 610; t++) begin
            time_v = 64'(t);
            applyStimulus("cke_hold", (t == 600) || (t == 610), 0, 1, 8'd0);
        end
        cke = 1'b1; time_v = 64'd611;
        applyStimulus("fire_after_cke", 1, 1, PA, 8'd0);
        time_v = 64'd612; ack = 1'b1;
        applyStimulus("ack_d", 1, 0, 0, 8'd0);

        // New target is used one cycle after the write
        time_v = 64'd700; setCmp(64'd1000); arm = 1'b1;
        applyStimulus("arm_w", 1, 0, 1, 8'd0);
        time_v = 64'd701; setCmp(64'd500);
        applyStimulus("wen_not_yet", 1, 0, 1, 8'd0);
        time_v = 64'd702;
        applyStimulus("wen_next", 1, 1, PA, 8'd0);
        time_v = 64'd703; disarm = 1'b1;
        applyStimulus("disarm_w", 1, 0, 0, 8'd0);

        // Asynchronous reset while pending
        time_v = 64'd800; setCmp(64'd10); arm = 1'b1;
        applyStimulus("arm_e", 1, 0, 1, 8'd0);
        time_v = 64'd801;
        applyStimulus("pending_e", 1, 1, PA, 8'd0);
        asyncResetCheck("async_reset_pending");
        time_v = 64'd900;
        applyStimulus("post_reset", 1, 0, 0, 8'd0);

`ifdef IOB_TIMER_ALARM_PERIODIC_EN
        // Target reload wraps together with the timer
        time_v = 64'hFFFF_FFFF_FFFF_FFFA; setCmp(64'hFFFF_FFFF_FFFF_FFF0);
        period_v = 64'h20; period_wen = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'hFFFF_FFFF_FFFF_FFFE; arm = 1'b1;
        applyStimulus("arm_f", 1, 0, 1, 8'd0);
        time_v = 64'hFFFF_FFFF_FFFF_FFFF;
        applyStimulus("wrap_fire", 1, 1, 1, 8'd0);
        time_v = 64'd0; ack = 1'b1;
        applyStimulus("wrap_ack", 1, 0, 1, 8'd0);
        for (int t = 1; t <= 15; t++) begin
            time_v = 64'(t);
            applyStimulus("no_refire_before_0x10", t == 15, 0, 1, 8'd0);
        end
        time_v = 64'h10;
        applyStimulus("wrap_second_fire", 1, 1, 1, 8'd0);
        time_v = 64'h11; ack = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h12; disarm = 1'b1;
        applyStimulus("disarm_f", 1, 0, 0, 8'd0);

        // Period 4 without acknowledge: missed events accumulate
        time_v = 64'h20; setCmp(64'h40); period_v = 64'd4; period_wen = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h21; arm = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        for (int t = 'h22; t <= 'h3F; t++) begin
            time_v = 64'(t);
            applyStimulus("", 0, 0, 0, 8'd0);
        end
        time_v = 64'h40;
        applyStimulus("periodic_fire", 1, 1, 1, 8'd0);
        for (int t = 'h41; t <= 'h4B; t++) begin
            time_v = 64'(t);
            if (t == 'h44)      applyStimulus("missed_1", 1, 1, 1, 8'd1);
            else if (t == 'h48) applyStimulus("missed_2", 1, 1, 1, 8'd2);
            else                applyStimulus("irq_held", t == 'h4B, 1, 1, 8'd2);
        end
        time_v = 64'h4C; ack = 1'b1;
        applyStimulus("ack_hit_same", 1, 1, 1, 8'd3);
        time_v = 64'h4D; ack = 1'b1;
        applyStimulus("ack_periodic", 1, 0, 1, 8'd3);
        time_v = 64'h4E;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h4F;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h50; ack = 1'b1;
        applyStimulus("ack_hit_no_miss", 1, 1, 1, 8'd3);

        // Zero period falls back to one-shot
        time_v = 64'h51; period_v = 64'd0; period_wen = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h52;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h53;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h54;
        applyStimulus("zero_period_oneshot", 1, 1, 1, 8'd4);
        time_v = 64'h55;
        applyStimulus("pending_holds", 1, 1, 1, 8'd4);
        asyncResetCheck("async_reset_periodic");

        // Hit every cycle until the missed counter saturates
        time_v = 64'h100; setCmp(64'h100); period_v = 64'd1; period_wen = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        time_v = 64'h101; arm = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
        for (int i = 0; i < 300; i++) begin
            time_v = time_v + 64'd1;
            applyStimulus("missed_saturate", i == 299, 1, 1, 8'd255);
        end
        time_v = time_v + 64'd1; disarm = 1'b1;
        applyStimulus("disarm_keeps_missed", 1, 0, 0, 8'd255);
        time_v = time_v + 64'd1; arm = 1'b1;
        applyStimulus("arm_clears_missed", 1, 0, 1, 8'd0);
        time_v = time_v + 64'd1; disarm = 1'b1;
        applyStimulus("", 0, 0, 0, 8'd0);
`endif

        applyStimulus("", 0, 0, 0, 8'd0);
        applyStimulus("", 0, 0, 0, 8'd0);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
